// File: rtl/frame_scanout.sv
// frame_scanout: VGA scan-out side of a double-buffered frame SRAM.
// Generates 640x480@60 timing and reads pixels from the displayed buffer.
// It grants write slots to the drawer and swaps buffers at vblank.
// Ports:
//   Clk, Reset_n   - 2x pixel clock, async active-low reset
//   frame_done     - drawer has finished the back buffer
//   mem_rdata      - SRAM read data, valid one Clk after mem_rd
//   mem_addr       - SRAM read address (0 outside read slots)
//   mem_rd, wr_en  - read strobe / drawer write grant
//   buffer_using   - buffer owned by the drawer
//   frame_clk_edge - {prev,cur} swap tick, 01 then 10
//   hs, vs, blank  - active-low syncs and blanking
//   pix_color      - colour index, 0 while blanked
module frame_scanout #(
    parameter int H_VIS   = 640,
    parameter int H_TOT   = 800,
    parameter int V_VIS   = 480,
    parameter int V_TOT   = 525,
    parameter int HS_BEG  = 656,
    parameter int HS_END  = 752,
    parameter int VS_BEG  = 490,
    parameter int VS_END  = 492,
    parameter int BUF_OFS = 307200
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_done,
    input  logic [7:0]  mem_rdata,
    output logic [19:0] mem_addr,
    output logic        mem_rd,
    output logic        wr_en,
    output logic        buffer_using,
    output logic [1:0]  frame_clk_edge,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic [7:0]  pix_color
);

    localparam logic [9:0] HVIS = 10'(H_VIS);
    localparam logic [9:0] HLST = 10'(H_TOT - 1);
    localparam logic [9:0] VVIS = 10'(V_VIS);
    localparam logic [9:0] VLST = 10'(V_TOT - 1);
    localparam logic [9:0] HSB  = 10'(HS_BEG);
    localparam logic [9:0] HSE  = 10'(HS_END);
    localparam logic [9:0] VSB  = 10'(VS_BEG);
    localparam logic [9:0] VSE  = 10'(VS_END);

    typedef enum logic {SCAN, SWAP} state_t;

    state_t      state, state_nx;
    logic        phase;
    logic [9:0]  hc, vc;
    logic        visible, rd_slot;
    logic        hs_raw, vs_raw;
    logic        hs_d, vs_d, blank_d;
    logic        cur, cur_d;
    logic [19:0] base, pix_ofs;

    assign visible = (hc < HVIS) && (vc < VVIS);
    assign rd_slot = ~phase & visible;
    assign hs_raw  = ~((hc >= HSB) && (hc < HSE));
    assign vs_raw  = ~((vc >= VSB) && (vc < VSE));

    // Scanout shows ~buffer_using, so buffer 1 is read while the drawer owns 0.
    assign base    = buffer_using ? 20'd0 : 20'(BUF_OFS);
    assign pix_ofs = 20'(vc) * 20'(H_VIS) + 20'(hc);

    // Slot strobes are decoded straight from the counters so that the read
    // for a pixel goes out in its own phase-0 cycle; reset masks them.
    assign mem_rd   = Reset_n & rd_slot;
    assign wr_en    = Reset_n & ~rd_slot;
    assign mem_addr = mem_rd ? base + pix_ofs : 20'd0;

    assign frame_clk_edge = {cur_d, cur};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase <= 1'b0;
            hc    <= 10'd0;
            vc    <= 10'd0;
        end else begin
            phase <= ~phase;
            if (phase) begin
                if (hc == HLST) begin
                    hc <= 10'd0;
                    vc <= (vc == VLST) ? 10'd0 : vc + 10'd1;
                end else begin
                    hc <= hc + 10'd1;
                end
            end
        end
    end

    // Syncs/blank take two Clk to line up with the returned pixel.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hs_d      <= 1'b1;
            vs_d      <= 1'b1;
            blank_d   <= 1'b1;
            hs        <= 1'b1;
            vs        <= 1'b1;
            blank     <= 1'b1;
            pix_color <= 8'd0;
        end else begin
            hs_d    <= hs_raw;
            vs_d    <= vs_raw;
            blank_d <= ~visible;
            hs      <= hs_d;
            vs      <= vs_d;
            blank   <= blank_d;
            if (phase) begin
                pix_color <= blank_d ? 8'd0 : mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            SCAN: begin
                if (~phase && hc == 10'd0 && vc == VVIS && frame_done) begin
                    state_nx = SWAP;
                end
            end
            SWAP:    state_nx = SCAN;
            default: state_nx = SCAN;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= SCAN;
            buffer_using <= 1'b0;
            cur          <= 1'b0;
            cur_d        <= 1'b0;
        end else begin
            state        <= state_nx;
            buffer_using <= buffer_using ^ (state == SWAP);
            cur          <= (state == SWAP);
            cur_d        <= cur;
        end
    end

endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: directed bench for frame_scanout on a reduced raster.
// A cycle-indexed raster model predicts every output each Clk.
module tb_frame_scanout;

    localparam int HV = 16, HT = 24, VV = 6, VT = 10;
    localparam int HSB = 18, HSE = 21, VSB = 7, VSE = 8;
    localparam int OFS = 96;
    localparam int FRAME = HT * VT * 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_done = 1'b0;
    logic [7:0]  mem_rdata = 8'd0;
    logic [19:0] mem_addr;
    logic        mem_rd, wr_en, buffer_using;
    logic [1:0]  frame_clk_edge;
    logic        hs, vs, blank;
    logic [7:0]  pix_color;

    frame_scanout #(
        .H_VIS(HV), .H_TOT(HT), .V_VIS(VV), .V_TOT(VT),
        .HS_BEG(HSB), .HS_END(HSE), .VS_BEG(VSB), .VS_END(VSE),
        .BUF_OFS(OFS)
    ) dut (
        .Clk(clk), .Reset_n(rst_n), .frame_done(frame_done),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .wr_en(wr_en), .buffer_using(buffer_using),
        .frame_clk_edge(frame_clk_edge), .hs(hs), .vs(vs),
        .blank(blank), .pix_color(pix_color)
    );

    always #5 clk = ~clk;

    int   t = 0;
    bit   run = 1'b0;
    int   swap_t = -100;
    logic m_bu = 1'b0;
    int   n_chk = 0, n_fail = 0;
    int   hs_lo = 0, vs_lo = 0, vis_cnt = 0;
    logic [19:0] hist [4];
    logic [7:0]  nxt_d;

    function automatic logic [7:0] mem_f(input logic [19:0] a);
        if (a == 20'd133) return 8'h46;
        return a[7:0] ^ {a[3:0], a[7:4]} ^ 8'h5A;
    endfunction

    function automatic int hc_of(input int c);
        return (c / 2) % HT;
    endfunction

    function automatic int vc_of(input int c);
        return (c / 2 / HT) % VT;
    endfunction

    function automatic bit vis_of(input int c);
        return hc_of(c) < HV && vc_of(c) < VV;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got %0h want %0h", nm, t, act, exp);
        end
    endtask

    // SRAM: answers a read in the following cycle, junk otherwise.
    always @(negedge clk)
        nxt_d = mem_rd ? mem_f(mem_addr) : 8'($urandom);
    always @(posedge clk) begin
        #1;
        mem_rdata = nxt_d;
    end

    // Cycle index and buffer model; a swap lands 2 Clk after vblank start.
    always @(posedge clk) begin
        if (run) begin
            if (t % 2 == 0 && hc_of(t) == 0 && vc_of(t) == VV && frame_done)
                swap_t = t;
            t = t + 1;
            if (t == swap_t + 2) m_bu = ~m_bu;
        end
    end

    int          c_s;
    bit          c_rd, c_vis;
    logic [19:0] c_a;
    logic [1:0]  c_edge;

    always @(negedge clk) begin
        if (run) begin
            c_rd = (t % 2 == 0) && vis_of(t);
            c_a  = c_rd ? 20'((m_bu ? 0 : OFS) + vc_of(t) * HV + hc_of(t))
                        : 20'd0;
            hist[t % 4] = c_a;
            c_edge = (t == swap_t + 2) ? 2'b01 :
                     (t == swap_t + 3) ? 2'b10 : 2'b00;
            check("mem_rd", 32'(mem_rd), 32'(c_rd));
            check("wr_en", 32'(wr_en), 32'(!c_rd));
            check("mem_addr", 32'(mem_addr), 32'(c_a));
            check("buffer_using", 32'(buffer_using), 32'(m_bu));
            check("frame_clk_edge", 32'(frame_clk_edge), 32'(c_edge));
            if (t >= 2) begin
                c_s   = (t - 2) - ((t - 2) % 2);
                c_vis = vis_of(c_s);
                check("hs", 32'(hs),
                      32'(!(hc_of(c_s) >= HSB && hc_of(c_s) < HSE)));
                check("vs", 32'(vs),
                      32'(!(vc_of(c_s) >= VSB && vc_of(c_s) < VSE)));
                check("blank", 32'(blank), 32'(!c_vis));
                check("pix_color", 32'(pix_color),
                      32'(c_vis ? mem_f(hist[c_s % 4]) : 8'd0));
                if (t < 2 + FRAME) begin
                    if (!hs) hs_lo++;
                    if (!vs) vs_lo++;
                    if (!blank) vis_cnt++;
                end
            end else begin
                check("hs_idle", 32'(hs), 32'd1);
                check("vs_idle", 32'(vs), 32'd1);
                check("blank_idle", 32'(blank), 32'd1);
                check("pix_idle", 32'(pix_color), 32'd0);
            end
        end
    end

    task automatic at_t(input int n);
        do @(negedge clk); while (t < n);
    endtask

    task automatic check_reset();
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_bu", 32'(buffer_using), 32'd0);
        check("rst_edge", 32'(frame_clk_edge), 32'd0);
        check("rst_hs", 32'(hs), 32'd1);
        check("rst_vs", 32'(vs), 32'd1);
        check("rst_blank", 32'(blank), 32'd1);
        check("rst_pix", 32'(pix_color), 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        t = 0;
        m_bu = 1'b0;
        swap_t = -100;
        run = 1'b1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset();
        frame_done = 1'b1;
        release_reset();

        at_t(0);
        check("first_rd", 32'(mem_rd), 32'd1);
        check("first_addr", 32'(mem_addr), 32'd96);
        at_t(106);
        check("addr_5_2", 32'(mem_addr), 32'd133);
        at_t(108);
        check("pix_5_2", 32'(pix_color), 32'h46);
        check("blank_5_2", 32'(blank), 32'd0);

        at_t(288);
        check("bu_before", 32'(buffer_using), 32'd0);
        at_t(290);
        check("bu_swapped", 32'(buffer_using), 32'd1);
        check("edge_01", 32'(frame_clk_edge), 32'd1);
        at_t(291);
        check("edge_10", 32'(frame_clk_edge), 32'd2);
        at_t(300);
        frame_done = 1'b0;

        at_t(2 + FRAME);
        check("hs_low_cnt", 32'(hs_lo), 32'd60);
        check("vs_low_cnt", 32'(vs_lo), 32'd48);
        check("visible_cnt", 32'(vis_cnt), 32'd192);

        at_t(FRAME + 291);
        check("no_swap_bu", 32'(buffer_using), 32'd1);
        check("no_swap_edge", 32'(frame_clk_edge), 32'd0);

        at_t(2 * FRAME + 2 * 3 * HT);
        frame_done = 1'b1;
        at_t(2 * FRAME + 2 * 3 * HT + 2);
        frame_done = 1'b0;
        at_t(2 * FRAME + 291);
        check("mid_pulse_bu", 32'(buffer_using), 32'd1);

        at_t(3 * FRAME + 10);
        frame_done = 1'b1;
        at_t(3 * FRAME + 290);
        check("swap_back_bu", 32'(buffer_using), 32'd0);
        check("swap_back_edge", 32'(frame_clk_edge), 32'd1);
        at_t(3 * FRAME + 300);
        frame_done = 1'b0;

        at_t(3 * FRAME + 361);
        #2;
        rst_n = 1'b0;
        run = 1'b0;
        #1 check_reset();
        release_reset();
        at_t(0);
        check("re_rd", 32'(mem_rd), 32'd1);
        check("re_addr", 32'(mem_addr), 32'd96);
        at_t(2 * HT);
        check("re_line1", 32'(mem_addr), 32'd112);
        at_t(300);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
